// File: rtl/piccolo_pkg.sv
`default_nettype none
// ============================================================================
//  piccolo_pkg
//  Shared widths and FSM state encoding for the Piccolo-128 I/O controller.
//  Revision: 1.0
// ============================================================================
package piccolo_pkg;

    localparam int PICCOLO_KEY_W = 128;
    localparam int PICCOLO_BLK_W = 64;
    localparam int WORD_W        = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        OUT_HI = 3'd3,
        OUT_LO = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/piccolo_word_packer.sv
`default_nettype none
// ============================================================================
//  piccolo_word_packer
//  Assembles N_WORDS 32-bit words into a big-endian block; the first word
//  lands in bits [0:31]. The slot counter wraps after the last word.
//  blk_nxt is the block value including a write in progress this cycle.
//  Revision: 1.0
// ============================================================================
module piccolo_word_packer
    import piccolo_pkg::*;
#(
    parameter int N_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [WORD_W-1:0]           wr_word,
    output logic [0:N_WORDS*WORD_W-1]   blk_nxt,
    output logic                        last
);

    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_WORDS - 1);

    logic [0:N_WORDS*WORD_W-1] blk_q, blk_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    assign last    = (cnt_q == LAST_SLOT);
    assign blk_nxt = blk_d;

    // Write the incoming word into the current slot and advance the slot.
    always_comb begin
        blk_d = blk_q;
        cnt_d = cnt_q;
        if (wr_en) begin
            blk_d[int'(cnt_q)*WORD_W +: WORD_W] = wr_word;
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Block and slot registers; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q <= '0;
            cnt_q <= '0;
        end else begin
            blk_q <= blk_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piccolo128_io_ctrl.sv
`default_nettype none
// ============================================================================
//  piccolo128_io_ctrl
//  Stream front/back end for the Piccolo-128 core: collects key and
//  plaintext words, pulses core_load, waits the core latency, captures the
//  ciphertext and returns it as two words (high word first).
//  Revision: 1.0
// ============================================================================
module piccolo128_io_ctrl
    import piccolo_pkg::*;
#(
    parameter int CORE_LATENCY = 2,
    parameter int CNT_W        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   in_data,
    input  logic          in_is_key,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          key_loaded,
    output logic          err_nokey,
    output logic          core_load,
    output logic [0:63]   core_plaintext,
    output logic [0:127]  core_key,
    input  logic [0:63]   core_ciphertext
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LATENCY - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [0:PICCOLO_BLK_W-1]  ct_q, ct_d;
    logic [0:PICCOLO_BLK_W-1]  core_pt_q, core_pt_d;
    logic [0:PICCOLO_KEY_W-1]  core_key_q, core_key_d;
    logic                      key_loaded_q, key_loaded_d;
    logic                      err_nokey_q, err_nokey_d;

    logic                      xfer;
    logic                      key_wr;
    logic                      pt_wr;
    logic                      key_last;
    logic                      pt_last;
    logic [0:PICCOLO_KEY_W-1]  key_blk_nxt;
    logic [0:PICCOLO_BLK_W-1]  pt_blk_nxt;

    assign in_ready = (state_q == IDLE) && !reset;
    assign xfer     = in_valid && in_ready;
    assign key_wr   = xfer && in_is_key;
    // Plaintext without a complete key is swallowed and only flags an error.
    assign pt_wr    = xfer && !in_is_key && key_loaded_q;

    piccolo_word_packer #(.N_WORDS(PICCOLO_KEY_W / WORD_W)) u_key_packer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (key_wr),
        .wr_word (in_data),
        .blk_nxt (key_blk_nxt),
        .last    (key_last)
    );

    piccolo_word_packer #(.N_WORDS(PICCOLO_BLK_W / WORD_W)) u_pt_packer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pt_wr),
        .wr_word (in_data),
        .blk_nxt (pt_blk_nxt),
        .last    (pt_last)
    );

    // Next-state logic: block sequencing, latency count, ciphertext capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ct_d         = ct_q;
        core_pt_d    = core_pt_q;
        core_key_d   = core_key_q;
        // A key reload clears key_loaded on its first word until it wraps.
        key_loaded_d = key_wr ? key_last : key_loaded_q;
        err_nokey_d  = err_nokey_q | (xfer && !in_is_key && !key_loaded_q);
        case (state_q)
            IDLE: begin
                if (pt_wr && pt_last) begin
                    // Latch core operands so they stay stable until the next LOAD.
                    core_pt_d  = pt_blk_nxt;
                    core_key_d = key_blk_nxt;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    ct_d    = core_ciphertext;
                    state_d = OUT_HI;
                end
            end
            OUT_HI: begin
                if (out_ready) state_d = OUT_LO;
            end
            OUT_LO: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        core_load = (state_q == LOAD);
        out_valid = (state_q == OUT_HI) || (state_q == OUT_LO);
        out_data  = '0;
        if (state_q == OUT_HI) out_data = ct_q[0:31];
        if (state_q == OUT_LO) out_data = ct_q[32:63];
    end

    assign key_loaded     = key_loaded_q;
    assign err_nokey      = err_nokey_q;
    assign core_plaintext = core_pt_q;
    assign core_key       = core_key_q;

    // Controller state registers; reset drops any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ct_q         <= '0;
            core_pt_q    <= '0;
            core_key_q   <= '0;
            key_loaded_q <= 1'b0;
            err_nokey_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ct_q         <= ct_d;
            core_pt_q    <= core_pt_d;
            core_key_q   <= core_key_d;
            key_loaded_q <= key_loaded_d;
            err_nokey_q  <= err_nokey_d;
        end
    end

endmodule
`default_nettype wire
